// File: rtl/monitor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : monitor_pkg
//  Description : Shared constants and sequence helpers for the dice / traffic
//                light bus monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
package monitor_pkg;

    // Traffic light codes, bit order {red, amber, green}
    localparam logic [2:0] RED      = 3'b100;
    localparam logic [2:0] RED_AMB  = 3'b110;
    localparam logic [2:0] GREEN    = 3'b001;
    localparam logic [2:0] AMBER    = 3'b010;

    // Dice face limits
    localparam logic [2:0] DICE_MIN = 3'd1;
    localparam logic [2:0] DICE_MAX = 3'd6;

    // Which source a channel models
    typedef enum logic {
        KIND_DICE  = 1'b0,
        KIND_LIGHT = 1'b1
    } chan_kind_e;

    function automatic logic dice_legal(input logic [2:0] v);
        return (v >= DICE_MIN) && (v <= DICE_MAX);
    endfunction

    function automatic logic [2:0] dice_succ(input logic [2:0] v);
        return (v >= DICE_MAX) ? DICE_MIN : v + 3'd1;
    endfunction

    function automatic logic light_legal(input logic [2:0] v);
        return (v == RED) || (v == RED_AMB) || (v == GREEN) || (v == AMBER);
    endfunction

    function automatic logic [2:0] light_succ(input logic [2:0] v);
        logic [2:0] n;
        case (v)
            RED:     n = RED_AMB;
            RED_AMB: n = GREEN;
            GREEN:   n = AMBER;
            default: n = RED;
        endcase
        return n;
    endfunction

endpackage : monitor_pkg
`default_nettype wire

// File: rtl/mon_channel.sv
`default_nettype none
// ============================================================================
//  Module      : mon_channel
//  Description : Reference model of one bus source (dice or lights). Tracks
//                the expected value and lock state and flags a mismatch when
//                the channel is active and locked.
//  Revision    : 1.0 - initial release
// ============================================================================
module mon_channel
    import monitor_pkg::*;
#(
    parameter chan_kind_e KIND = KIND_DICE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       active,
    input  logic       button,
    input  logic [2:0] result,
    output logic       locked,
    output logic       mismatch
);

    logic       r_locked;
    logic [2:0] r_exp;
    logic       w_legal;
    logic       w_match;

    // Next expected value after x; the dice only moves while its button is held
    function automatic logic [2:0] step(input logic [2:0] x, input logic b);
        if (KIND == KIND_DICE)
            return b ? dice_succ(x) : x;
        else
            return light_succ(x);
    endfunction

    // Legality and match of the current bus value against the model
    always_comb begin
        w_legal = (KIND == KIND_DICE) ? dice_legal(result) : light_legal(result);
        w_match = (result == r_exp);
    end

    // Lock tracking and model advance; resync on a legal mismatch, drop lock on an illegal one
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_locked <= 1'b0;
            r_exp    <= 3'd0;
        end else if (active) begin
            if (!r_locked) begin
                if (w_legal) begin
                    r_locked <= 1'b1;
                    r_exp    <= step(result, button);
                end
            end else if (w_match || w_legal) begin
                r_exp <= step(result, button);
            end else begin
                r_locked <= 1'b0;
                r_exp    <= step(r_exp, button);
            end
        end else if (r_locked) begin
            r_exp <= step(r_exp, button);
        end
    end

    assign locked   = r_locked;
    assign mismatch = active && r_locked && !w_match;

endmodule : mon_channel
`default_nettype wire

// File: rtl/dice_light_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : dice_light_monitor
//  Description : Receive-side checker of the shared dice / traffic-light bus.
//                Two background models, registered error strobe, last error
//                source, sticky flag and saturating error counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module dice_light_monitor
    import monitor_pkg::*;
#(
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 sel,
    input  logic                 button,
    input  logic [2:0]           result,
    output logic                 dice_locked,
    output logic                 light_locked,
    output logic                 err_pulse,
    output logic                 err_src,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [ERR_CNT_W-1:0] c_cnt_one = ERR_CNT_W'(1);
    localparam logic [ERR_CNT_W-1:0] c_cnt_max = '1;

    logic                 w_dice_mis;
    logic                 w_light_mis;
    logic                 w_err;
    logic                 r_err_pulse;
    logic                 r_err_src;
    logic                 r_err_sticky;
    logic [ERR_CNT_W-1:0] r_err_count;

    mon_channel #(.KIND(KIND_DICE)) u_dice (
        .clk      (clk),
        .rst      (rst),
        .active   (sel),
        .button   (button),
        .result   (result),
        .locked   (dice_locked),
        .mismatch (w_dice_mis)
    );

    mon_channel #(.KIND(KIND_LIGHT)) u_light (
        .clk      (clk),
        .rst      (rst),
        .active   (!sel),
        .button   (button),
        .result   (result),
        .locked   (light_locked),
        .mismatch (w_light_mis)
    );

    assign w_err = w_dice_mis || w_light_mis;

    // Error reporting; a coincident error beats clr and restarts the count at one
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err_pulse  <= 1'b0;
            r_err_src    <= 1'b0;
            r_err_sticky <= 1'b0;
            r_err_count  <= '0;
        end else begin
            r_err_pulse <= w_err;
            if (w_err) begin
                r_err_src    <= sel;
                r_err_sticky <= 1'b1;
                if (clr)
                    r_err_count <= c_cnt_one;
                else if (r_err_count != c_cnt_max)
                    r_err_count <= r_err_count + c_cnt_one;
            end else if (clr) begin
                r_err_sticky <= 1'b0;
                r_err_count  <= '0;
            end
        end
    end

    assign err_pulse  = r_err_pulse;
    assign err_src    = r_err_src;
    assign err_sticky = r_err_sticky;
    assign err_count  = r_err_count;

endmodule : dice_light_monitor
`default_nettype wire

// File: tb/tb_dice_light_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dice_light_monitor
//  Description : Directed self-checking bench for dice_light_monitor. A second
//                instance with a 2-bit counter shares the stimulus to exercise
//                counter saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dice_light_monitor;
    import monitor_pkg::*;

    localparam int c_half = 5;

    logic       clk = 1'b0;
    logic       rst, clr, sel, button;
    logic [2:0] result;

    logic       dice_locked, light_locked, err_pulse, err_src, err_sticky;
    logic [7:0] err_count;
    logic       s_dice_locked, s_light_locked, s_err_pulse, s_err_src, s_err_sticky;
    logic [1:0] s_err_count;

    int n_cmp = 0;
    int n_mis = 0;

    always #c_half clk = ~clk;

    dice_light_monitor #(.ERR_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .clr(clr), .sel(sel), .button(button), .result(result),
        .dice_locked(dice_locked), .light_locked(light_locked), .err_pulse(err_pulse),
        .err_src(err_src), .err_sticky(err_sticky), .err_count(err_count)
    );

    dice_light_monitor #(.ERR_CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .clr(clr), .sel(sel), .button(button), .result(result),
        .dice_locked(s_dice_locked), .light_locked(s_light_locked), .err_pulse(s_err_pulse),
        .err_src(s_err_src), .err_sticky(s_err_sticky), .err_count(s_err_count)
    );

    // One clock of stimulus; outputs are sampled 1 time unit after the edge
    task automatic drive(input logic s, input logic b, input logic [2:0] r);
        sel = s; button = b; result = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; clr = 1'b0;
        drive(1'b0, 1'b0, 3'd0);
        drive(1'b0, 1'b0, 3'd0);
        n_cmp++; if (dice_locked !== 1'b0) begin n_mis++; $display("FAIL reset_dice_locked: got %b want 0", dice_locked); end
        n_cmp++; if (light_locked !== 1'b0) begin n_mis++; $display("FAIL reset_light_locked: got %b want 0", light_locked); end
        n_cmp++; if (err_pulse !== 1'b0) begin n_mis++; $display("FAIL reset_err_pulse: got %b want 0", err_pulse); end
        n_cmp++; if (err_src !== 1'b0) begin n_mis++; $display("FAIL reset_err_src: got %b want 0", err_src); end
        n_cmp++; if (err_sticky !== 1'b0) begin n_mis++; $display("FAIL reset_err_sticky: got %b want 0", err_sticky); end
        n_cmp++; if (err_count !== 8'd0) begin n_mis++; $display("FAIL reset_err_count: got %0d want 0", err_count); end
        rst = 1'b1;
    endtask

    task automatic test_dice_lock_hold();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 3'd3);
            n_cmp++; if (dice_locked !== 1'b1) begin n_mis++; $display("FAIL hold_locked[%0d]: got %b want 1", i, dice_locked); end
            n_cmp++; if (err_pulse !== 1'b0) begin n_mis++; $display("FAIL hold_pulse[%0d]: got %b want 0", i, err_pulse); end
        end
        n_cmp++; if (err_count !== 8'd0) begin n_mis++; $display("FAIL hold_count: got %0d want 0", err_count); end
    endtask

    task automatic test_dice_wrap();
        logic [2:0] seq [4];
        seq = '{3'd5, 3'd6, 3'd1, 3'd2};
        drive(1'b1, 1'b1, 3'd3);   // expected 3, model moves to 4
        drive(1'b1, 1'b1, 3'd4);   // model moves to 5
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, seq[i]);
            n_cmp++; if (err_pulse !== 1'b0) begin n_mis++; $display("FAIL wrap_pulse[%0d]: got %b want 0", i, err_pulse); end
        end
        drive(1'b1, 1'b1, 3'd4);   // 3 expected
        n_cmp++; if (err_pulse !== 1'b1) begin n_mis++; $display("FAIL wrap_err_pulse: got %b want 1", err_pulse); end
        n_cmp++; if (err_src !== 1'b1) begin n_mis++; $display("FAIL wrap_err_src: got %b want 1", err_src); end
        n_cmp++; if (err_count !== 8'd1) begin n_mis++; $display("FAIL wrap_err_count: got %0d want 1", err_count); end
        n_cmp++; if (err_sticky !== 1'b1) begin n_mis++; $display("FAIL wrap_err_sticky: got %b want 1", err_sticky); end
        drive(1'b1, 1'b1, 3'd5);   // resynced model expects 5
        n_cmp++; if (err_pulse !== 1'b0) begin n_mis++; $display("FAIL wrap_resync_pulse: got %b want 0", err_pulse); end
        n_cmp++; if (err_count !== 8'd1) begin n_mis++; $display("FAIL wrap_resync_count: got %0d want 1", err_count); end
    endtask

    task automatic test_lights_background();
        drive(1'b0, 1'b0, RED);
        n_cmp++; if (light_locked !== 1'b1) begin n_mis++; $display("FAIL light_lock: got %b want 1", light_locked); end
        n_cmp++; if (err_pulse !== 1'b0) begin n_mis++; $display("FAIL light_lock_pulse: got %b want 0", err_pulse); end
        drive(1'b1, 1'b0, 3'd6);   // dice holds at 6 with the button released
        drive(1'b1, 1'b0, 3'd6);
        n_cmp++; if (err_pulse !== 1'b0) begin n_mis++; $display("FAIL light_bg_dice_pulse: got %b want 0", err_pulse); end
        drive(1'b0, 1'b0, AMBER);
        n_cmp++; if (err_pulse !== 1'b0) begin n_mis++; $display("FAIL light_bg_amber: got %b want 0", err_pulse); end
        drive(1'b0, 1'b0, GREEN);  // RED expected
        n_cmp++; if (err_pulse !== 1'b1) begin n_mis++; $display("FAIL light_err_pulse: got %b want 1", err_pulse); end
        n_cmp++; if (err_src !== 1'b0) begin n_mis++; $display("FAIL light_err_src: got %b want 0", err_src); end
        n_cmp++; if (err_count !== 8'd2) begin n_mis++; $display("FAIL light_err_count: got %0d want 2", err_count); end
        drive(1'b0, 1'b0, AMBER);
        n_cmp++; if (err_pulse !== 1'b0) begin n_mis++; $display("FAIL light_resync: got %b want 0", err_pulse); end
    endtask

    task automatic test_illegal();
        drive(1'b1, 1'b0, 3'd7);
        n_cmp++; if (err_pulse !== 1'b1) begin n_mis++; $display("FAIL illegal_pulse: got %b want 1", err_pulse); end
        n_cmp++; if (dice_locked !== 1'b0) begin n_mis++; $display("FAIL illegal_unlock: got %b want 0", dice_locked); end
        n_cmp++; if (err_count !== 8'd3) begin n_mis++; $display("FAIL illegal_count: got %0d want 3", err_count); end
        drive(1'b1, 1'b0, 3'd2);
        n_cmp++; if (err_pulse !== 1'b0) begin n_mis++; $display("FAIL relock_pulse: got %b want 0", err_pulse); end
        n_cmp++; if (dice_locked !== 1'b1) begin n_mis++; $display("FAIL relock_locked: got %b want 1", dice_locked); end
        drive(1'b1, 1'b0, 3'd2);
        n_cmp++; if (err_pulse !== 1'b0) begin n_mis++; $display("FAIL relock_hold: got %b want 0", err_pulse); end
    endtask

    task automatic test_reset_mid_run();
        n_cmp++; if (light_locked !== 1'b1) begin n_mis++; $display("FAIL pre_rst_light_locked: got %b want 1", light_locked); end
        n_cmp++; if (err_count !== 8'd3) begin n_mis++; $display("FAIL pre_rst_count: got %0d want 3", err_count); end
        rst = 1'b0; clr = 1'b1;
        drive(1'b1, 1'b0, 3'd7);
        rst = 1'b1; clr = 1'b0;
        n_cmp++; if (dice_locked !== 1'b0) begin n_mis++; $display("FAIL mid_rst_dice_locked: got %b want 0", dice_locked); end
        n_cmp++; if (light_locked !== 1'b0) begin n_mis++; $display("FAIL mid_rst_light_locked: got %b want 0", light_locked); end
        n_cmp++; if (err_pulse !== 1'b0) begin n_mis++; $display("FAIL mid_rst_pulse: got %b want 0", err_pulse); end
        n_cmp++; if (err_src !== 1'b0) begin n_mis++; $display("FAIL mid_rst_src: got %b want 0", err_src); end
        n_cmp++; if (err_sticky !== 1'b0) begin n_mis++; $display("FAIL mid_rst_sticky: got %b want 0", err_sticky); end
        n_cmp++; if (err_count !== 8'd0) begin n_mis++; $display("FAIL mid_rst_count: got %0d want 0", err_count); end
        drive(1'b1, 1'b0, 3'd4);
        n_cmp++; if (err_pulse !== 1'b0) begin n_mis++; $display("FAIL post_rst_dice_pulse: got %b want 0", err_pulse); end
        n_cmp++; if (dice_locked !== 1'b1) begin n_mis++; $display("FAIL post_rst_dice_locked: got %b want 1", dice_locked); end
        drive(1'b0, 1'b0, GREEN);
        n_cmp++; if (err_pulse !== 1'b0) begin n_mis++; $display("FAIL post_rst_light_pulse: got %b want 0", err_pulse); end
        n_cmp++; if (light_locked !== 1'b1) begin n_mis++; $display("FAIL post_rst_light_locked: got %b want 1", light_locked); end
        n_cmp++; if (err_count !== 8'd0) begin n_mis++; $display("FAIL post_rst_count: got %0d want 0", err_count); end
    endtask

    task automatic test_saturation_clear();
        logic [2:0] bad [5];
        bad = '{3'd5, 3'd4, 3'd5, 3'd4, 3'd5};  // dice model holds 4, each value resyncs it
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, bad[i]);
            n_cmp++; if (s_err_pulse !== 1'b1) begin n_mis++; $display("FAIL sat_pulse[%0d]: got %b want 1", i, s_err_pulse); end
        end
        n_cmp++; if (s_err_count !== 2'd3) begin n_mis++; $display("FAIL sat_count_small: got %0d want 3", s_err_count); end
        n_cmp++; if (err_count !== 8'd5) begin n_mis++; $display("FAIL sat_count_wide: got %0d want 5", err_count); end
        clr = 1'b1;
        drive(1'b1, 1'b0, 3'd5);
        n_cmp++; if (s_err_pulse !== 1'b0) begin n_mis++; $display("FAIL clr_pulse: got %b want 0", s_err_pulse); end
        n_cmp++; if (s_err_sticky !== 1'b0) begin n_mis++; $display("FAIL clr_sticky: got %b want 0", s_err_sticky); end
        n_cmp++; if (s_err_count !== 2'd0) begin n_mis++; $display("FAIL clr_count: got %0d want 0", s_err_count); end
        n_cmp++; if (err_count !== 8'd0) begin n_mis++; $display("FAIL clr_count_wide: got %0d want 0", err_count); end
        drive(1'b1, 1'b0, 3'd1);   // error together with clr
        clr = 1'b0;
        n_cmp++; if (s_err_count !== 2'd1) begin n_mis++; $display("FAIL clr_err_count: got %0d want 1", s_err_count); end
        n_cmp++; if (s_err_sticky !== 1'b1) begin n_mis++; $display("FAIL clr_err_sticky: got %b want 1", s_err_sticky); end
        n_cmp++; if (err_count !== 8'd1) begin n_mis++; $display("FAIL clr_err_count_wide: got %0d want 1", err_count); end
    endtask

    initial begin
        rst = 1'b0; clr = 1'b0; sel = 1'b0; button = 1'b0; result = 3'd0;
        test_reset();
        test_dice_lock_hold();
        test_dice_wrap();
        test_lights_background();
        test_illegal();
        test_reset_mid_run();
        test_saturation_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule : tb_dice_light_monitor
`default_nettype wire
